// File: rtl/arb_pkg.sv
// Shared definitions for the 16-way round-robin arbiter slice.
//   NREQ        : number of requesters
//   SEL_W       : width of a requester index / mux select
//   sel_t       : requester index type
//   out_state_t : occupancy of the single-entry output register
package arb_pkg;

  localparam int NREQ  = 16;
  localparam int SEL_W = 4;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/mux_16.sv
// 16:1 word multiplexer.
//   s       : select index
//   d0..d15 : candidate words
//   y       : selected word
module mux_16
  import arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  sel_t             s,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  input  logic [WIDTH-1:0] d8,
  input  logic [WIDTH-1:0] d9,
  input  logic [WIDTH-1:0] d10,
  input  logic [WIDTH-1:0] d11,
  input  logic [WIDTH-1:0] d12,
  input  logic [WIDTH-1:0] d13,
  input  logic [WIDTH-1:0] d14,
  input  logic [WIDTH-1:0] d15,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (s)
      4'd0:    y = d0;
      4'd1:    y = d1;
      4'd2:    y = d2;
      4'd3:    y = d3;
      4'd4:    y = d4;
      4'd5:    y = d5;
      4'd6:    y = d6;
      4'd7:    y = d7;
      4'd8:    y = d8;
      4'd9:    y = d9;
      4'd10:   y = d10;
      4'd11:   y = d11;
      4'd12:   y = d12;
      4'd13:   y = d13;
      4'd14:   y = d14;
      4'd15:   y = d15;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb_16.sv
// Sixteen-requester round-robin arbiter feeding a single valid/ready
// output register.
//   clk, rst  : clock, synchronous active-high reset
//   req       : per-source request
//   in_data   : per-source word (in_data[i] belongs to source i)
//   gnt       : combinational one-hot grant (zero when nothing is taken)
//   out_valid : output register holds a word
//   out_ready : downstream takes the output word this cycle
//   out_data  : captured word
//   out_src   : source index that produced out_data
module rr_arb_16
  import arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][WIDTH-1:0] in_data,
  output logic [NREQ-1:0]            gnt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output sel_t                       out_src
);

  out_state_t       state_q;
  out_state_t       state_d;
  sel_t             ptr;
  sel_t             winner;
  logic             can_accept;
  logic             grant;
  logic [WIDTH-1:0] mux_y;

  // Rotate the request vector so that index ptr lands at bit 0, take the
  // lowest set bit, then add ptr back (mod 16) to recover the real index.
  function automatic sel_t find_winner(input logic [NREQ-1:0] r, input sel_t p);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    sel_t              idx;
    dbl = {r, r} >> p;
    rot = dbl[NREQ-1:0];
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = sel_t'(i);
    end
    return idx + p;
  endfunction

  assign out_valid  = (state_q == OUT_FULL);
  assign can_accept = !out_valid || out_ready;
  assign winner     = find_winner(req, ptr);
  // The grant never depends on in_data, only on requests and occupancy.
  assign grant      = can_accept && (|req) && !rst;
  assign gnt        = grant ? ({{(NREQ-1){1'b0}}, 1'b1} << winner) : '0;

  mux_16 #(.WIDTH(WIDTH)) u_mux (
    .s  (winner),
    .d0 (in_data[0]),
    .d1 (in_data[1]),
    .d2 (in_data[2]),
    .d3 (in_data[3]),
    .d4 (in_data[4]),
    .d5 (in_data[5]),
    .d6 (in_data[6]),
    .d7 (in_data[7]),
    .d8 (in_data[8]),
    .d9 (in_data[9]),
    .d10(in_data[10]),
    .d11(in_data[11]),
    .d12(in_data[12]),
    .d13(in_data[13]),
    .d14(in_data[14]),
    .d15(in_data[15]),
    .y  (mux_y)
  );

  // Occupancy: a grant always leaves the register full (refill on drain);
  // a drain with no grant empties it; a stall holds it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (grant) state_d = OUT_FULL;
      OUT_FULL: begin
        if (grant)          state_d = OUT_FULL;
        else if (out_ready) state_d = OUT_EMPTY;
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  // Priority only rotates on an actual grant, so idle and stalled cycles
  // leave the next-up source unchanged. Data/src are held across a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= OUT_EMPTY;
      out_data <= '0;
      out_src  <= '0;
      ptr      <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        out_data <= mux_y;
        out_src  <= winner;
        ptr      <= winner + sel_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_16.sv
// Self-checking bench for rr_arb_16: a table of directed vectors with
// hand-derived expectations, a short hand-written withdrawal sequence, and
// a randomized phase compared against a behavioural reference model.
module tb_rr_arb_16;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       req;
  logic [15:0][31:0] inData;
  logic [15:0]       gnt;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [3:0]        out_src;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int          mPtr   = 0;
  logic        mValid = 1'b0;
  logic [31:0] mData  = '0;
  int          mSrc   = 0;
  logic [15:0] expGnt;
  logic [15:0] gntSeen;

  typedef struct {
    logic        rstv;
    logic [15:0] reqv;
    logic        rdy;
    logic [31:0] data4;
    logic [15:0] eGnt;
    logic        eValid;
    logic [31:0] eData;
    logic [3:0]  eSrc;
  } vec_t;

  vec_t vecs[$];

  rr_arb_16 #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .in_data  (inData),
    .gnt      (gnt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_src  (out_src)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [15:0] q, input logic rd,
                              input logic [31:0] d4, input logic [15:0] g,
                              input logic v, input logic [31:0] d, input logic [3:0] s);
    vec_t t;
    t.rstv = r; t.reqv = q; t.rdy = rd; t.data4 = d4;
    t.eGnt = g; t.eValid = v; t.eData = d; t.eSrc = s;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, samples gnt mid-cycle, advances past the
  // clock edge and updates the reference model. The model picks the first
  // requesting index counting upward from the priority pointer.
  task automatic applyStimulus(input logic r, input logic [15:0] q, input logic rdy);
    int win;
    rst = r; req = q; out_ready = rdy;
    #4;
    gntSeen = gnt;
    win = -1;
    if (!r && (q != 0) && (!mValid || rdy)) begin
      for (int k = 0; k < 16; k++) begin
        if (win < 0 && q[(mPtr + k) % 16]) win = (mPtr + k) % 16;
      end
    end
    expGnt = (win >= 0) ? (16'd1 << win) : 16'd0;
    @(posedge clk);
    #1;
    if (r) begin
      mPtr = 0; mValid = 1'b0; mData = '0; mSrc = 0;
    end else if (win >= 0) begin
      mData = inData[win]; mSrc = win; mValid = 1'b1; mPtr = (win + 1) % 16;
    end else if (mValid && rdy) begin
      mValid = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] reqState;
    rst = 1'b1; req = '0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) inData[i] = 32'(i);

    // Reset with everyone requesting, then a single request.
    vecs.push_back(mk(1, 16'hFFFF, 1, 32'd4, 16'h0000, 0, 32'd0, 4'd0));
    vecs.push_back(mk(1, 16'hFFFF, 1, 32'd4, 16'h0000, 0, 32'd0, 4'd0));
    vecs.push_back(mk(0, 16'hFFFF, 1, 32'd4, 16'h0001, 1, 32'd0, 4'd0));
    vecs.push_back(mk(0, 16'h0010, 1, 32'hDEAD_BEEF, 16'h0010, 1, 32'hDEAD_BEEF, 4'd4));
    vecs.push_back(mk(0, 16'h0000, 1, 32'd4, 16'h0000, 0, 32'hDEAD_BEEF, 4'd4));
    // Re-reset so full contention starts at source 0.
    vecs.push_back(mk(1, 16'h0000, 1, 32'd4, 16'h0000, 0, 32'd0, 4'd0));
    for (int k = 0; k < 18; k++)
      vecs.push_back(mk(0, 16'hFFFF, 1, 32'd4, 16'd1 << (k % 16), 1, 32'(k % 16), 4'(k % 16)));
    // Backpressure holding source 2.
    vecs.push_back(mk(0, 16'h0004, 1, 32'd4, 16'h0004, 1, 32'd2, 4'd2));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 16'h0030, 0, 32'd4, 16'h0000, 1, 32'd2, 4'd2));
    vecs.push_back(mk(0, 16'h0030, 1, 32'd4, 16'h0010, 1, 32'd4, 4'd4));
    // Wrap and idle.
    vecs.push_back(mk(0, 16'h4000, 1, 32'd4, 16'h4000, 1, 32'd14, 4'd14));
    vecs.push_back(mk(0, 16'h0000, 1, 32'd4, 16'h0000, 0, 32'd14, 4'd14));
    vecs.push_back(mk(0, 16'h0000, 1, 32'd4, 16'h0000, 0, 32'd14, 4'd14));
    vecs.push_back(mk(0, 16'h8001, 1, 32'd4, 16'h8000, 1, 32'd15, 4'd15));
    vecs.push_back(mk(0, 16'h8001, 1, 32'd4, 16'h0001, 1, 32'd0, 4'd0));
    // Mid-operation reset while full (source 8 requesting).
    vecs.push_back(mk(0, 16'h0100, 0, 32'd4, 16'h0000, 1, 32'd0, 4'd0));
    vecs.push_back(mk(1, 16'h0100, 1, 32'd4, 16'h0000, 0, 32'd0, 4'd0));
    vecs.push_back(mk(0, 16'h0101, 1, 32'd4, 16'h0001, 1, 32'd0, 4'd0));

    foreach (vecs[n]) begin
      inData[4] = vecs[n].data4;
      applyStimulus(vecs[n].rstv, vecs[n].reqv, vecs[n].rdy);
      checkOutput($sformatf("vec%0d gnt", n), 32'(gntSeen), 32'(vecs[n].eGnt));
      checkOutput($sformatf("vec%0d valid", n), 32'(out_valid), 32'(vecs[n].eValid));
      checkOutput($sformatf("vec%0d data", n), out_data, vecs[n].eData);
      checkOutput($sformatf("vec%0d src", n), 32'(out_src), 32'(vecs[n].eSrc));
    end

    // Withdrawal: source 1 asks during a stall, then drops before being
    // granted; the arbiter must ignore it. Priority pointer is now 1.
    inData[4] = 32'd4;
    applyStimulus(1'b0, 16'h0002, 1'b0);
    checkOutput("wd stall gnt", 32'(gntSeen), 32'h0);
    checkOutput("wd stall valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("wd drop gnt", 32'(gntSeen), 32'h0);
    checkOutput("wd drop valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 16'h0040, 1'b1);
    checkOutput("wd next gnt", 32'(gntSeen), 32'h0040);
    checkOutput("wd next src", 32'(out_src), 32'd6);
    checkOutput("wd next data", out_data, 32'd6);

    // Randomized phase: requesters obey the hold-until-granted contract
    // with occasional withdrawals, random backpressure and rare resets.
    reqState = '0;
    for (int c = 0; c < 400; c++) begin
      logic r;
      logic rdy;
      for (int i = 0; i < 16; i++) begin
        if (!reqState[i] && $urandom_range(3) == 0) begin
          reqState[i] = 1'b1;
          inData[i] = $urandom;
        end else if (reqState[i] && $urandom_range(31) == 0) begin
          reqState[i] = 1'b0;
        end
      end
      r   = ($urandom_range(63) == 0);
      rdy = ($urandom_range(3) != 0);
      applyStimulus(r, reqState, rdy);
      checkOutput("rnd gnt", 32'(gntSeen), 32'(expGnt));
      checkOutput("rnd valid", 32'(out_valid), 32'(mValid));
      checkOutput("rnd data", out_data, mData);
      checkOutput("rnd src", 32'(out_src), 32'(mSrc));
      reqState = reqState & ~expGnt;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rr_arb_16.md
# rr_arb_16

Sixteen-requester round-robin arbiter with a registered output stage. It sits directly upstream of the 16:1 word mux and drives its 4-bit select from the arbitration winner. It captures the selected word into a single valid/ready output register and returns a one-hot grant to the winning requester. It gives fair, starvation-free access to a shared 32-bit consumer.

## Interface
- `WIDTH`, 32, data word width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous and active-high.
- `req`  in  16  request per source; bit i asserted means `in_data[i]` is valid.
- `in_data`  in  16×WIDTH  packed array; `in_data[i]` is the word offered by source i.
- `gnt`  out  16  one-hot combinational grant, or zero. `gnt[i]`=1 means source i's word is taken at this clock edge.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  downstream accepts the output this cycle.
- `out_data`  out  WIDTH  captured word.
- `out_src`  out  4  index of the source that produced `out_data`.

## Operation
- Internal state:
  - `ptr` (4 bits): the highest-priority index for the next arbitration.
  - output register: `out_valid`, `out_data`, `out_src`.
- Output register states:
  - EMPTY (`out_valid`=0).
  - FULL (`out_valid`=1).
- `can_accept` = !`out_valid` | `out_ready`.
- Winner: the first i with `req[i]`=1, scanning ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16).
- `gnt` = onehot(winner) when `can_accept` & |`req` & !`rst`; otherwise 0.
- On a grant edge:
  - `out_data` <= `in_data[winner]`, read through the 16:1 mux with sel=winner.
  - `out_src` <= winner.
  - `out_valid` <= 1.
  - `ptr` <= winner+1; 4-bit wrap, so 15 -> 0.
- Drain without refill: when `out_valid` & `out_ready` & no grant, `out_valid` <= 0. `out_data`/`out_src` keep their last values.
- When there is no grant, `ptr` is unchanged. Idle cycles do not rotate priority.
- Transitions:
  - EMPTY -> FULL on a grant.
  - FULL -> FULL on drain with a simultaneous grant, or on a stall (`out_ready`=0).
  - FULL -> EMPTY on drain with no request.
- Requester contract: hold `req[i]` and `in_data[i]` stable until `gnt[i]`. The arbiter never grants a source whose `req` is 0.
- Withdrawing a request before it is granted is legal and is simply ignored.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_src`=0, `ptr`=0. `gnt`=0 while `rst`=1 regardless of `req`.
- Reset mid-operation discards a held output word. Any request granted in the reset cycle is not granted; `gnt` is forced to 0.
- `gnt` is a combinational function of `req`, `ptr`, `out_valid`, `out_ready` and `rst`. There is no path from `in_data` to `gnt`.
- Latency: grant at edge N gives `out_valid`=1 with the data from cycle N+1.
- Throughput: one word per cycle while `out_ready`=1 and any `req` is set.
- Stall: while `out_valid`=1 and `out_ready`=0, `out_data`/`out_src` are stable, `gnt`=0 and `ptr` is frozen.
- Fairness: a continuously requesting source is granted within 16 grants.

## Structure
- Shared package `arb_pkg`:
  - `NREQ`=16, `SEL_W`=4.
  - typedef `sel_t` = logic [SEL_W-1:0].
- Sub-module: one instance of `mux_16` (WIDTH passed through), with s=winner and d0..d15=`in_data[0..15]`.
- Winner search: a rotate-by-`ptr`, priority-encode, un-rotate function, written inline in this module.
- No other sub-modules.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `req`=16'hFFFF, `out_ready`=1.
  - Required: `gnt`=0 throughout; after release `out_valid`=0, `out_data`=0, `out_src`=0.
  - First grant is `gnt`=16'h0001.
- Single request: `req`=16'h0010, `in_data[4]`=32'hDEAD_BEEF, `out_ready`=1.
  - Required: `gnt`=16'h0010 in the same cycle.
  - Next cycle: `out_valid`=1, `out_data`=32'hDEAD_BEEF, `out_src`=4.
- Full contention: `req`=16'hFFFF held, `in_data[i]`=i, `out_ready`=1.
  - Required: `out_src` sequence 0,1,…,15,0,1 on consecutive cycles, with `out_data`=`out_src`.
- Backpressure: output FULL holding source 2, set `out_ready`=0 for 3 cycles with `req`=16'h0030.
  - Required: `gnt`=0 and `out_data` unchanged during the stall.
  - On `out_ready`=1: `gnt`=16'h0010 in that same cycle, then `out_src`=4.
- Wrap and idle: grant 14, idle 2 cycles (`req`=0), then `req`=16'h8001.
  - Required: grants 15 then 0.
  - `out_valid` falls to 0 during idle while `out_ready`=1.
- Mid-operation reset: assert `rst` while FULL and `req`=16'h0100.
  - Required: next cycle `out_valid`=0, `gnt`=0 during reset.
  - After release, `ptr`=0, so with `req`=16'h0101 the first grant is 16'h0001.
